// File: rtl/apb_pkg.sv
// Shared types for the APB multi-requester bridge.
// FSM states and request kinds used by apb_multi_master.
package apb_pkg;

  localparam int unsigned PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB slave decoder: the lowest matching slave index wins.
// Produces a hit flag and a one-hot (or zero) select vector.
module apb_addr_decoder #(
  parameter int unsigned AW_APB = 32,
  parameter int unsigned N_SLV  = 4,
  parameter logic [N_SLV-1:0][AW_APB-1:0] SLV_BASE = '0,
  parameter logic [N_SLV-1:0][AW_APB-1:0] SLV_MASK = '0
) (
  input  logic [AW_APB-1:0] addr,
  output logic              hit,
  output logic [N_SLV-1:0]  sel
);

  // Scan downwards so the lowest matching index is the last writer.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i]) == SLV_BASE[i]) begin
        hit    = 1'b1;
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_multi_master.sv
// APB master shared by a read and a write requester, round-robin arbitrated.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
module apb_multi_master
  import apb_pkg::*;
#(
  parameter int unsigned AW_APB      = 32,
  parameter int unsigned DW_APB      = 32,
  parameter int unsigned N_SLV       = 4,
  parameter logic [N_SLV-1:0][AW_APB-1:0] SLV_BASE = {
    32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000
  },
  parameter logic [N_SLV-1:0][AW_APB-1:0] SLV_MASK = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000
  },
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                    apb_clk,
  input  logic                    sys_reset,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [AW_APB-1:0]       wr_addr,
  input  logic [DW_APB-1:0]       wr_data,
  input  logic [DW_APB/8-1:0]     wr_strb,
  input  logic [PROT_W-1:0]       wr_prot,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [AW_APB-1:0]       rd_addr,
  input  logic [PROT_W-1:0]       rd_prot,
  output logic                    wr_resp_valid,
  output logic                    wr_resp_err,
  output logic                    rd_resp_valid,
  output logic                    rd_resp_err,
  output logic [DW_APB-1:0]       rd_data,
  output logic [AW_APB-1:0]       paddr,
  output logic [DW_APB-1:0]       pwdata,
  output logic [DW_APB/8-1:0]     pstrb,
  output logic [PROT_W-1:0]       pprot,
  output logic                    pwrite,
  output logic                    penable,
  output logic [N_SLV-1:0]        psel,
  input  logic [N_SLV*DW_APB-1:0] prdata,
  input  logic [N_SLV-1:0]        pready,
  input  logic [N_SLV-1:0]        pslverr
);

  state_t             state;
  req_type_t          last_type;
  req_type_t          gnt_type;
  logic [N_SLV-1:0]   slv_sel;
  logic [AW_APB-1:0]  req_addr;
  logic               dec_hit;
  logic [N_SLV-1:0]   dec_sel;
  logic               sel_ready;
  logic               sel_err;
  logic [DW_APB-1:0]  sel_rdata;
  logic               pick_rd;
  logic               granted;
  logic               cap_valid;
  logic               accept;
  logic               tmo;
  logic               fin;
  logic               fin_err;
  logic [DW_APB-1:0]  fin_data;

  assign req_addr = (gnt_type == READ) ? rd_addr : wr_addr;

  apb_addr_decoder #(
    .AW_APB   (AW_APB),
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (req_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (slv_sel[i]) begin
        sel_rdata = sel_rdata | prdata[i*DW_APB +: DW_APB];
      end
    end
  end

  assign sel_ready = |(pready & slv_sel);
  assign sel_err   = |(pslverr & slv_sel);

  // Read wins a tie unless it was the last type granted.
  assign pick_rd   = rd_req_valid && (!wr_req_valid || last_type == WRITE);
  assign granted   = rd_req_ready || wr_req_ready;
  assign cap_valid = (gnt_type == READ) ? rd_req_valid : wr_req_valid;
  assign accept    = (state == IDLE) && granted && cap_valid;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge apb_clk) begin
    if (sys_reset || state != ACCESS) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign tmo = (state == ACCESS) && !sel_ready
            && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  assign fin      = (accept && !dec_hit)
                 || (state == ACCESS && (sel_ready || tmo));
  assign fin_err  = (state == ACCESS && sel_ready) ? sel_err : 1'b1;
  assign fin_data = fin_err ? '0 : sel_rdata;

  always_ff @(posedge apb_clk) begin
    if (sys_reset) begin
      state         <= IDLE;
      last_type     <= WRITE;
      gnt_type      <= READ;
      slv_sel       <= '0;
      wr_req_ready  <= 1'b0;
      rd_req_ready  <= 1'b0;
      wr_resp_valid <= 1'b0;
      wr_resp_err   <= 1'b0;
      rd_resp_valid <= 1'b0;
      rd_resp_err   <= 1'b0;
      rd_data       <= '0;
      paddr         <= '0;
      pwdata        <= '0;
      pstrb         <= '0;
      pprot         <= '0;
      pwrite        <= 1'b0;
      penable       <= 1'b0;
      psel          <= '0;
    end else begin
      wr_req_ready  <= 1'b0;
      rd_req_ready  <= 1'b0;
      wr_resp_valid <= 1'b0;
      wr_resp_err   <= 1'b0;
      rd_resp_valid <= 1'b0;
      rd_resp_err   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (granted) begin
            if (cap_valid) begin
              last_type <= gnt_type;
              slv_sel   <= dec_sel;
              paddr     <= req_addr;
              pwrite    <= (gnt_type == WRITE);
              pwdata    <= wr_data;
              pstrb     <= (gnt_type == WRITE) ? wr_strb : '0;
              pprot     <= (gnt_type == WRITE) ? wr_prot : rd_prot;
              if (dec_hit) begin
                psel  <= dec_sel;
                state <= SETUP;
              end else begin
                state <= RESP;
              end
            end
          end else if (rd_req_valid || wr_req_valid) begin
            gnt_type     <= pick_rd ? READ : WRITE;
            rd_req_ready <= pick_rd;
            wr_req_ready <= !pick_rd;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready || tmo) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (fin) begin
        if (gnt_type == READ) begin
          rd_resp_valid <= 1'b1;
          rd_resp_err   <= fin_err;
          rd_data       <= fin_data;
        end else begin
          wr_resp_valid <= 1'b1;
          wr_resp_err   <= fin_err;
        end
      end
    end
  end

endmodule
